fifo_rd_sched: RTL and testbench
================================

# fifo_rd_sched

Read-side scheduler for the asynchronous FIFO. It shares the FIFO read port among NREQ consumers in the read clock domain. It grants bounded bursts round-robin and drives the FIFO read-increment from the FIFO's registered empty flag. Each popped word goes into a one-entry output register with a per-consumer valid/ready handshake. The block sits between the FIFO read-pointer/empty logic plus memory read port and the downstream consumers.

## Interface
- DSIZE, default 8: data word width.
- NREQ, default 4: number of consumers; must be at least 2.
- MAXBURST, default 4: maximum words popped per grant; must be at least 1.
- rclk  in  1  read-domain clock; all state is on the rising edge.
- rrst_n  in  1  reset; asynchronous assert, active-low.
- rempty  in  1  registered FIFO empty flag.
- rdata  in  DSIZE  FIFO memory read data at the current read address; valid whenever rempty=0.
- rinc  out  1  FIFO pop; combinational.
- req  in  NREQ  level request per consumer.
- rdy  in  NREQ  per-consumer ready.
- gnt  out  NREQ  registered, one-hot or zero; the current burst owner.
- dvalid  out  NREQ  registered, one-hot or zero; output-register valid for its owner.
- dout  out  DSIZE  output register data.

## Operation
- State machine states: IDLE, BURST, DRAIN.
- **IDLE → BURST:** taken when any req is high and rempty=0.
  - Winner is the first requester found searching upward (with wrap) from index rrptr.
  - gnt is loaded one-hot, bcnt is cleared, and rrptr is set to winner+1 mod NREQ.
- **Pop rule:** rinc = (state==BURST) & ~rempty & req[owner] & (~hval | take).
  - take = dvalid[owner] & rdy[owner].
  - On a pop: hold ← rdata, hval ← 1, bcnt increments.
  - On a take with no pop: hval ← 0.
- **BURST → DRAIN:** taken on any of the following.
  - A pop that makes bcnt reach MAXBURST.
  - req[owner]=0.
  - rempty=1 while no pop occurs.
- **DRAIN → IDLE:** taken once hval=0 or take occurs; gnt clears in the same edge. No pop occurs in DRAIN.
- dvalid = gnt & {NREQ{hval}}. dout holds its value when hval=0.
- rinc is never high while rempty=1.
- The owner never changes while hval=1.
- bcnt width is clog2(MAXBURST+1). rrptr width is clog2(NREQ) and wraps NREQ-1 → 0.

## Timing
- **Reset values:** state=IDLE, gnt=0, dvalid=0, dout=0, hval=0, bcnt=0, rrptr=0. rinc=0 during reset.
- **Arbitration:** the grant is visible 1 cycle after req and ~rempty are seen in IDLE. The first rinc can come in that same granted cycle.
- **Data latency:** a word popped in cycle t shows dvalid/dout from cycle t+1.
- **Throughput:** with rdy held high, one word per cycle.
- **Re-arbitration gap:** IDLE plus a one-cycle DRAIN gives a 2-cycle gap between bursts.
- **Simultaneous take and pop:** hval stays 1 and the new word replaces the old one; no bubble.
- **rdy low:** hold stalls and rinc stays 0 until the take.
- **req[owner] drops with hval=1:** the word already held is still delivered in DRAIN and waits for rdy. The consumer must accept it.
- **Reset mid-operation:** all state returns to reset values immediately. A held word is discarded. The FIFO pointer has already advanced past it, so the word is lost by design.

## Structure
- Shared package fifo_pkg holds the state enum (IDLE, BURST, DRAIN).
- Sub-module fifo_rr_arb is combinational. It takes req and rrptr and produces a one-hot winner and its index.
- fifo_rd_sched holds the state machine, counters and output register.

## Test plan
- **Single consumer, continuous:** reset, preload FIFO with 0x10..0x17, req=0001, rdy=1111, MAXBURST=4 → dout sequence 0x10..0x13 on dvalid[0] in 4 back-to-back cycles, DRAIN, re-grant, then 0x14..0x17; rinc never high once rempty=1.
- **Round-robin fairness:** 12 words, req=1111 constant → bursts granted to 0,1,2 in that order, 4 words each.
- **Backpressure:** rdy[owner]=0 for 3 cycles mid-burst → dout is stable, rinc=0 for those cycles, no word lost or duplicated.
- **Empty mid-burst:** 2 words in the FIFO, req=0010 → 2 transfers, DRAIN, IDLE, gnt=0; a later write gives a new grant to consumer 1.
- **Request drop:** req[owner] drops after the first pop with rdy=0 → no further rinc; the held word is delivered when rdy rises; rrptr has moved past the owner.
- **Reset mid-burst:** assert rrst_n low with hval=1 → gnt, dvalid, dout, rinc all 0 immediately; after release the first grant goes to index 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types for the asynchronous FIFO read-side logic.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

endpackage

// File: rtl/fifo_rr_arb.sv
// Combinational round-robin search: first requester at or above rrptr, wrapping.
module fifo_rr_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rrptr,
  output logic [NREQ-1:0] win_oh,
  output logic [PW-1:0]   win_idx,
  output logic            win_any
);

  int unsigned k;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_any = 1'b0;
    k       = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      k = 32'(rrptr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (!win_any && req[k]) begin
        win_any    = 1'b1;
        win_oh[k]  = 1'b1;
        win_idx    = PW'(k);
      end
    end
  end

endmodule

// File: rtl/fifo_rd_sched.sv
// Read-side scheduler: round-robin bounded bursts from the FIFO read port into
// a one-entry output register with per-consumer valid/ready.
module fifo_rd_sched
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE    = 8,
  parameter int unsigned NREQ     = 4,
  parameter int unsigned MAXBURST = 4
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  rdy,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  dvalid,
  output logic [DSIZE-1:0] dout
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned BW = $clog2(MAXBURST + 1);

  rd_state_t        state, state_n;
  logic [NREQ-1:0]  gnt_n;
  logic [PW-1:0]    own, own_n;
  logic [PW-1:0]    rrptr, rrptr_n;
  logic [BW-1:0]    bcnt, bcnt_n;
  logic [DSIZE-1:0] hold, hold_n;
  logic             hval, hval_n;
  logic             take;

  logic [NREQ-1:0]  win_oh;
  logic [PW-1:0]    win_idx;
  logic             win_any;

  fifo_rr_arb #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req     (req),
    .rrptr   (rrptr),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .win_any (win_any)
  );

  assign dvalid = gnt & {NREQ{hval}};
  assign dout   = hold;
  assign take   = dvalid[own] & rdy[own];
  assign rinc   = (state == BURST) & ~rempty & req[own] & (~hval | take);

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    own_n   = own;
    rrptr_n = rrptr;
    bcnt_n  = bcnt;
    hold_n  = hold;
    hval_n  = hval;
    unique case (state)
      IDLE: begin
        if (win_any && !rempty) begin
          state_n = BURST;
          gnt_n   = win_oh;
          own_n   = win_idx;
          bcnt_n  = '0;
          rrptr_n = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
        end
      end
      BURST: begin
        // A simultaneous take and pop keeps hval set: the new word replaces the taken one.
        if (rinc) begin
          hold_n = rdata;
          hval_n = 1'b1;
          bcnt_n = bcnt + BW'(1);
        end else if (take) begin
          hval_n = 1'b0;
        end
        if ((rinc && bcnt_n == BW'(MAXBURST)) || !req[own] || (!rinc && rempty))
          state_n = DRAIN;
      end
      DRAIN: begin
        if (!hval || take) begin
          state_n = IDLE;
          gnt_n   = '0;
          hval_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state <= IDLE;
      gnt   <= '0;
      own   <= '0;
      rrptr <= '0;
      bcnt  <= '0;
      hold  <= '0;
      hval  <= 1'b0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      own   <= own_n;
      rrptr <= rrptr_n;
      bcnt  <= bcnt_n;
      hold  <= hold_n;
      hval  <= hval_n;
    end
  end

endmodule

// File: tb/tb_fifo_rd_sched.sv
// Bench for fifo_rd_sched: queue-level FIFO and scheduler model compared every cycle.
module tb_fifo_rd_sched;

  localparam int NR = 4;
  localparam int MB = 4;

  logic       rclk = 1'b0;
  logic       rrst_n = 1'b0;
  logic       rempty, rinc;
  logic [7:0] rdata, dout;
  logic [3:0] req = '0, rdy = '0, gnt, dvalid;

  logic [7:0] mem [0:255];
  int         wptr = 0, rptr = 0;

  int checks = 0, failures = 0;

  // Model of the scheduler in plain terms: owner index (-1 none), draining flag, held word.
  int         m_own = -1, m_cnt = 0, m_ptr = 0;
  bit         m_drain = 0, m_hv = 0;
  logic [7:0] m_dout = '0;
  int         dlv_data[$], dlv_own[$], grant_log[$];

  assign rempty = (rptr == wptr);
  assign rdata  = mem[rptr[7:0]];

  always #5 rclk = ~rclk;

  fifo_rd_sched #(.DSIZE(8), .NREQ(NR), .MAXBURST(MB)) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .rempty (rempty),
    .rdata  (rdata),
    .rinc   (rinc),
    .req    (req),
    .rdy    (rdy),
    .gnt    (gnt),
    .dvalid (dvalid),
    .dout   (dout)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_rinc();
    return (m_own >= 0) && !m_drain && !rempty && req[m_own] && (!m_hv || rdy[m_own]);
  endfunction

  function automatic logic [3:0] m_gnt();
    return (m_own >= 0) ? 4'(1 << m_own) : 4'b0;
  endfunction

  initial begin : model
    bit pop, tk;
    int w;
    forever begin
      @(posedge rclk or negedge rrst_n);
      if (!rrst_n) begin
        m_own = -1; m_drain = 0; m_cnt = 0; m_ptr = 0; m_hv = 0; m_dout = '0;
      end else begin
        pop = m_rinc();
        tk  = (m_own >= 0) && m_hv && rdy[m_own];
        if (tk) begin
          dlv_data.push_back(int'(m_dout));
          dlv_own.push_back(m_own);
        end
        if (m_own < 0) begin
          if (req != 0 && !rempty) begin
            w = -1;
            for (int i = 0; i < NR; i++) begin
              int k;
              k = (m_ptr + i) % NR;
              if (w < 0 && req[k]) w = k;
            end
            grant_log.push_back(w);
            m_own = w; m_cnt = 0; m_ptr = (w + 1) % NR;
          end
        end else if (!m_drain) begin
          if (pop) begin
            m_dout = rdata; m_hv = 1; m_cnt++;
          end else if (tk) begin
            m_hv = 0;
          end
          if ((pop && m_cnt == MB) || !req[m_own] || (!pop && rempty)) m_drain = 1;
        end else if (!m_hv || tk) begin
          m_own = -1; m_drain = 0; m_hv = 0;
        end
        if (pop) rptr <= rptr + 1;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge rclk);
      check("gnt", 32'(gnt), 32'(m_gnt()));
      check("dvalid", 32'(dvalid), m_hv ? 32'(m_gnt()) : 32'd0);
      check("dout", 32'(dout), 32'(m_dout));
      check("rinc", 32'(rinc), 32'(m_rinc()));
      check("rinc_while_empty", 32'(rinc & rempty), 32'd0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge rclk);
    #1;
  endtask

  task automatic push(input logic [7:0] x);
    mem[wptr[7:0]] = x;
    wptr++;
  endtask

  task automatic chk_dlv(input string nm, input int idx, input int data, input int own);
    check({nm, "_data"}, 32'(dlv_data.size() > idx ? dlv_data[idx] : -1), 32'(data));
    check({nm, "_own"},  32'(dlv_own.size()  > idx ? dlv_own[idx]  : -1), 32'(own));
  endtask

  initial begin : stim
    int s, g;
    logic [7:0] saved;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    // Reset state
    cyc(1);
    @(negedge rclk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_dvalid", 32'(dvalid), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_rinc", 32'(rinc), 32'd0);
    @(posedge rclk); #1;
    rrst_n = 1'b1;
    cyc(1);

    // Single consumer, two bursts of MAXBURST
    s = dlv_data.size();
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    req = 4'b0001; rdy = 4'b1111;
    cyc(20);
    req = '0;
    cyc(2);
    check("t1_count", 32'(dlv_data.size() - s), 32'd8);
    for (int i = 0; i < 8; i++) chk_dlv("t1", s + i, 8'h10 + i, 0);

    // Round-robin fairness from a fresh reset
    rrst_n = 1'b0; cyc(1); rrst_n = 1'b1; cyc(1);
    g = grant_log.size(); s = dlv_data.size();
    for (int i = 0; i < 12; i++) push(8'(8'h20 + i));
    req = 4'b1111; rdy = 4'b1111;
    cyc(30);
    req = '0;
    cyc(3);
    check("t2_grants", 32'(grant_log.size() - g), 32'd3);
    for (int i = 0; i < 3; i++)
      check("t2_order", 32'(grant_log.size() > g + i ? grant_log[g + i] : -1), 32'(i));
    for (int i = 0; i < 12; i++) chk_dlv("t2", s + i, 8'h20 + i, i / 4);

    // Backpressure mid-burst
    s = dlv_data.size();
    for (int i = 0; i < 6; i++) push(8'(8'h30 + i));
    req = 4'b0001; rdy = 4'b1111;
    cyc(3);
    rdy = 4'b0000;
    saved = dout;
    check("t3_saved", 32'(saved), 32'h31);
    repeat (3) begin
      @(negedge rclk);
      check("t3_stall_rinc", 32'(rinc), 32'd0);
      check("t3_stall_dout", 32'(dout), 32'(saved));
      cyc(1);
    end
    rdy = 4'b1111;
    cyc(15);
    req = '0;
    cyc(2);
    check("t3_count", 32'(dlv_data.size() - s), 32'd6);
    for (int i = 0; i < 6; i++) chk_dlv("t3", s + i, 8'h30 + i, 0);

    // Empty mid-burst, then a later write regrants
    s = dlv_data.size();
    push(8'h40); push(8'h41);
    req = 4'b0010; rdy = 4'b1111;
    cyc(8);
    @(negedge rclk);
    check("t4_idle_gnt", 32'(gnt), 32'd0);
    cyc(1);
    push(8'h42);
    cyc(1);
    @(negedge rclk);
    check("t4_regrant", 32'(gnt), 32'b0010);
    cyc(6);
    req = '0;
    cyc(2);
    for (int i = 0; i < 3; i++) chk_dlv("t4", s + i, 8'h40 + i, 1);

    // Request drop with a held word
    s = dlv_data.size();
    push(8'h50); push(8'h51); push(8'h52);
    req = 4'b0100; rdy = 4'b0000;
    cyc(2);
    req = 4'b0000;
    repeat (3) begin
      @(negedge rclk);
      check("t5_no_rinc", 32'(rinc), 32'd0);
      check("t5_held", 32'(dvalid), 32'b0100);
      cyc(1);
    end
    rdy = 4'b0100;
    cyc(1);
    req = 4'b1111; rdy = 4'b1111;
    g = grant_log.size();
    cyc(1);
    @(negedge rclk);
    check("t5_next_gnt", 32'(gnt), 32'b1000);
    check("t5_next_log", 32'(grant_log.size() > g ? grant_log[g] : -1), 32'd3);
    cyc(8);
    req = '0;
    cyc(2);
    chk_dlv("t5a", s, 8'h50, 2);
    chk_dlv("t5b", s + 1, 8'h51, 3);
    chk_dlv("t5c", s + 2, 8'h52, 3);

    // Reset mid-burst with hval set
    for (int i = 0; i < 4; i++) push(8'(8'h60 + i));
    req = 4'b0010; rdy = 4'b0000;
    cyc(2);
    @(negedge rclk);
    check("t6_pre_dvalid", 32'(dvalid), 32'b0010);
    check("t6_pre_dout", 32'(dout), 32'h60);
    cyc(1);
    rrst_n = 1'b0;
    #1;
    check("t6_rst_gnt", 32'(gnt), 32'd0);
    check("t6_rst_dvalid", 32'(dvalid), 32'd0);
    check("t6_rst_dout", 32'(dout), 32'd0);
    check("t6_rst_rinc", 32'(rinc), 32'd0);
    cyc(1);
    rrst_n = 1'b1;
    g = grant_log.size(); s = dlv_data.size();
    req = 4'b1111; rdy = 4'b1111;
    cyc(1);
    @(negedge rclk);
    check("t6_first_gnt", 32'(gnt), 32'b0001);
    cyc(8);
    req = '0;
    cyc(2);
    check("t6_log", 32'(grant_log.size() > g ? grant_log[g] : -1), 32'd0);
    for (int i = 0; i < 3; i++) chk_dlv("t6", s + i, 8'h61 + i, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
